// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM stage of the MIPS pipeline. Takes the registered
// EX/MEM outputs, runs one load/store per request on a req/ack data bus
// (big-endian byte lanes), holds the pipeline with stall_req while the access
// is in flight, and presents the write-back triple to MEM/WB.
// Optional build macro: MEM_ALIGN_CHECK_EN. When it is defined, misaligned
// half/word accesses skip the bus and raise excp_align. When it is not
// defined, no check is made, the low address bits are truncated, and
// excp_align is tied to 0.
module mem_access_unit #(
  parameter int BUS_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  mem_wd,
  input  logic        mem_wreg,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_op,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_sdata,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_sel,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic [4:0]  wb_wd,
  output logic        wb_wreg,
  output logic [31:0] wb_wdata,
  output logic        stall_req,
  output logic        bus_err,
  output logic        excp_align
);

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LBU = 4'd2;
  localparam logic [3:0] OP_LH  = 4'd3;
  localparam logic [3:0] OP_LHU = 4'd4;
  localparam logic [3:0] OP_LW  = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;

  // Counter only needs to reach BUS_TIMEOUT-1.
  localparam int CNT_W = (BUS_TIMEOUT > 1) ? $clog2(BUS_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((BUS_TIMEOUT > 0) ? BUS_TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] tmo_cnt;
  logic [31:0]      rdata_cap;
  logic             tmo_flag;
  logic             is_load, is_store, is_mem;
  logic             misalign, align_err;
  logic             tmo_hit, start_access;

  // Byte enables; bit3 is the byte at addr+0 (most significant lane).
  function automatic logic [3:0] lane_sel(input logic [3:0] op, input logic [1:0] a);
    logic [3:0] sel;
    case (op)
      OP_LB, OP_LBU, OP_SB: begin
        case (a)
          2'd0:    sel = 4'b1000;
          2'd1:    sel = 4'b0100;
          2'd2:    sel = 4'b0010;
          default: sel = 4'b0001;
        endcase
      end
      OP_LH, OP_LHU, OP_SH: sel = a[1] ? 4'b0011 : 4'b1100;
      default:              sel = 4'b1111;
    endcase
    return sel;
  endfunction

  // Stores replicate the datum across all lanes; bus_sel picks the live ones.
  function automatic logic [31:0] store_data(input logic [3:0] op, input logic [31:0] sdata);
    logic [31:0] d;
    case (op)
      OP_SB:   d = {4{sdata[7:0]}};
      OP_SH:   d = {2{sdata[15:0]}};
      default: d = sdata;
    endcase
    return d;
  endfunction

  // Pull the addressed lane(s) out of the read word and extend.
  function automatic logic [31:0] load_extract(input logic [3:0] op, input logic [1:0] a,
                                               input logic [31:0] rdata);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] d;
    case (a)
      2'd0:    b = rdata[31:24];
      2'd1:    b = rdata[23:16];
      2'd2:    b = rdata[15:8];
      default: b = rdata[7:0];
    endcase
    h = a[1] ? rdata[15:0] : rdata[31:16];
    case (op)
      OP_LB:   d = {{24{b[7]}}, b};
      OP_LBU:  d = {24'd0, b};
      OP_LH:   d = {{16{h[15]}}, h};
      OP_LHU:  d = {16'd0, h};
      default: d = rdata;
    endcase
    return d;
  endfunction

  assign is_load  = (mem_op >= OP_LB) && (mem_op <= OP_LW);
  assign is_store = (mem_op >= OP_SB) && (mem_op <= OP_SW);
  assign is_mem   = is_load || is_store;

`ifdef MEM_ALIGN_CHECK_EN
  logic align_flag;

  assign misalign = (((mem_op == OP_LH) || (mem_op == OP_LHU) || (mem_op == OP_SH)) && mem_addr[0]) ||
                    (((mem_op == OP_LW) || (mem_op == OP_SW)) && (mem_addr[1:0] != 2'd0));

  // Remember a misaligned request so DONE can report it and suppress write-back.
  always_ff @(posedge clk) begin
    if (rst)
      align_flag <= 1'b0;
    else if (state == IDLE)
      align_flag <= is_mem && misalign;
  end

  assign align_err  = align_flag;
  assign excp_align = (state == DONE) && align_flag;
`else
  assign misalign   = 1'b0;
  assign align_err  = 1'b0;
  assign excp_align = 1'b0;
`endif

  assign start_access = (state == IDLE) && is_mem && !misalign;
  assign tmo_hit      = (BUS_TIMEOUT != 0) && (state == BUSY) && !bus_ack && (tmo_cnt == CNT_LAST);
  assign bus_err      = (state == DONE) && tmo_flag;

  // State register.
  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_next;
  end

  // Next state, stall request and write-back selection.
  always_comb begin
    state_next = state;
    stall_req  = 1'b0;
    wb_wd      = mem_wd;
    wb_wreg    = mem_wreg;
    wb_wdata   = mem_wdata;
    case (state)
      IDLE: begin
        if (is_mem) begin
          stall_req  = 1'b1;
          wb_wreg    = 1'b0;
          state_next = misalign ? DONE : BUSY;
        end
      end
      BUSY: begin
        stall_req = 1'b1;
        wb_wreg   = 1'b0;
        if (bus_ack || tmo_hit)
          state_next = DONE;
      end
      DONE: begin
        state_next = IDLE;
        if (is_load && !tmo_flag && !align_err)
          wb_wdata = load_extract(mem_op, mem_addr[1:0], rdata_cap);
        else
          wb_wreg = 1'b0;
      end
      default: state_next = IDLE;
    endcase
  end

  // Bus request registers: launched from IDLE, dropped on ack or timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= 32'd0;
      bus_sel   <= 4'd0;
      bus_wdata <= 32'd0;
    end else if (start_access) begin
      bus_req   <= 1'b1;
      bus_we    <= is_store;
      bus_addr  <= {mem_addr[31:2], 2'b00};
      bus_sel   <= lane_sel(mem_op, mem_addr[1:0]);
      bus_wdata <= store_data(mem_op, mem_sdata);
    end else if ((state == BUSY) && (bus_ack || tmo_hit)) begin
      bus_req <= 1'b0;
    end
  end

  // Timeout counter: cleared at launch, counts BUSY cycles without ack.
  always_ff @(posedge clk) begin
    if (rst)
      tmo_cnt <= '0;
    else if (start_access)
      tmo_cnt <= '0;
    else if ((state == BUSY) && !bus_ack)
      tmo_cnt <= tmo_cnt + 1'b1;
  end

  // Read data capture on ack; only BUSY acks are honoured.
  always_ff @(posedge clk) begin
    if (rst)
      rdata_cap <= 32'd0;
    else if ((state == BUSY) && bus_ack)
      rdata_cap <= bus_rdata;
  end

  // Timeout flag: set on the aborting edge, held through DONE, cleared in IDLE.
  always_ff @(posedge clk) begin
    if (rst)
      tmo_flag <= 1'b0;
    else if (state == BUSY)
      tmo_flag <= tmo_hit;
    else if (state == IDLE)
      tmo_flag <= 1'b0;
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed cases plus randomized load/store/NOP traffic
// against a transaction-level reference of the MEM stage, with the bench
// acting as the bus slave (random ack latency, including timeouts).
module tb_mem_access_unit;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_op;
  logic [31:0] mem_addr;
  logic [31:0] mem_sdata;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_sel;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  logic [4:0]  wb_wd;
  logic        wb_wreg;
  logic [31:0] wb_wdata;
  logic        stall_req;
  logic        bus_err;
  logic        excp_align;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.BUS_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
    .mem_op(mem_op), .mem_addr(mem_addr), .mem_sdata(mem_sdata),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_sel(bus_sel),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
    .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata),
    .stall_req(stall_req), .bus_err(bus_err), .excp_align(excp_align)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Access size in bytes; 0 means NOP class.
  function automatic int m_bytes(input logic [3:0] op);
    case (op)
      4'd1, 4'd2, 4'd6: return 1;
      4'd3, 4'd4, 4'd7: return 2;
      4'd5, 4'd8:       return 4;
      default:          return 0;
    endcase
  endfunction

  // Byte offset of the accessed lane group within the word.
  function automatic int m_off(input int bytes, input logic [31:0] addr);
    if (bytes == 4) return 0;
    if (bytes == 2) return int'(addr[1:0]) & 2;
    return int'(addr[1:0]);
  endfunction

  function automatic logic [3:0] m_sel(input int bytes, input logic [31:0] addr);
    logic [3:0] full = 4'b1111;
    logic [3:0] grp;
    grp = full << (4 - bytes);
    return grp >> m_off(bytes, addr);
  endfunction

  function automatic logic [31:0] m_sdata(input int bytes, input logic [31:0] sdata);
    if (bytes == 1) return {24'd0, sdata[7:0]} * 32'h0101_0101;
    if (bytes == 2) return {16'd0, sdata[15:0]} * 32'h0001_0001;
    return sdata;
  endfunction

  function automatic logic [31:0] m_load(input logic [3:0] op, input int bytes,
                                         input logic [31:0] addr, input logic [31:0] rdata);
    logic [31:0] mask, v;
    if (bytes == 4) return rdata;
    mask = (32'd1 << (8 * bytes)) - 32'd1;
    v = (rdata >> (8 * (4 - bytes - m_off(bytes, addr)))) & mask;
    if (((op == 4'd1) || (op == 4'd3)) && v[8 * bytes - 1])
      v = v | ~mask;
    return v;
  endfunction

  function automatic bit m_misalign(input int bytes, input logic [31:0] addr);
`ifdef MEM_ALIGN_CHECK_EN
    return ((bytes == 2) && addr[0]) || ((bytes == 4) && (addr[1:0] != 2'd0));
`else
    return (bytes < 0) && addr[0];
`endif
  endfunction

  // One full transaction; ack_k = BUSY cycle (1-based) carrying ack, 0 = never.
  task automatic xact(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                      input logic [31:0] rdata, input int ack_k,
                      input logic [4:0] wd, input logic wreg, input logic [31:0] wdata);
    int  bytes;
    bit  is_ld, mis, to;
    bytes = m_bytes(op);
    is_ld = (bytes != 0) && (op <= 4'd5);
    mis   = (bytes != 0) && m_misalign(bytes, addr);
    to    = 1'b0;
    mem_op = op; mem_addr = addr; mem_sdata = sdata;
    mem_wd = wd; mem_wreg = wreg; mem_wdata = wdata;
    bus_ack = 1'($urandom % 2); bus_rdata = $urandom;
    @(negedge clk);
    chk("idle_stall", stall_req, bytes != 0);
    chk("idle_wreg", wb_wreg, (bytes != 0) ? 1'b0 : wreg);
    if (bytes == 0) begin
      chk("nop_wd", wb_wd, wd);
      chk("nop_wdata", wb_wdata, wdata);
    end
    chk("idle_req", bus_req, 0);
    chk("idle_err", bus_err, 0);
    chk("idle_align", excp_align, 0);
    @(posedge clk); #1;
    if (bytes == 0) return;
    if (!mis) begin
      to = 1'b1;
      for (int k = 1; k <= TMO; k++) begin
        bus_ack = (k == ack_k);
        bus_rdata = bus_ack ? rdata : $urandom;
        @(negedge clk);
        chk("busy_req", bus_req, 1);
        chk("busy_we", bus_we, !is_ld);
        chk("busy_addr", bus_addr, addr & ~32'd3);
        chk("busy_sel", bus_sel, m_sel(bytes, addr));
        if (!is_ld) chk("busy_wdata", bus_wdata, m_sdata(bytes, sdata));
        chk("busy_stall", stall_req, 1);
        chk("busy_wreg", wb_wreg, 0);
        @(posedge clk); #1;
        if (bus_ack) begin
          to = 1'b0;
          break;
        end
      end
    end
    bus_ack = 1'($urandom % 2); bus_rdata = $urandom;
    @(negedge clk);
    chk("done_req", bus_req, 0);
    chk("done_stall", stall_req, 0);
    chk("done_err", bus_err, to);
    chk("done_align", excp_align, mis);
    chk("done_wreg", wb_wreg, (is_ld && !to && !mis) ? wreg : 1'b0);
    if (is_ld && !to && !mis) begin
      chk("done_wd", wb_wd, wd);
      chk("done_wdata", wb_wdata, m_load(op, bytes, addr, rdata));
    end
    @(posedge clk); #1;
  endtask

  // Reset asserted mid-access: the request is abandoned without write-back.
  task automatic rst_in_busy();
    mem_op = 4'd5; mem_addr = 32'h0000_0300; mem_wreg = 1'b1; bus_ack = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rbusy_req", bus_req, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    mem_op = 4'd0; mem_wd = 5'd9; mem_wreg = 1'b1; mem_wdata = 32'h55;
    @(negedge clk);
    chk("rbusy_req_low", bus_req, 0);
    chk("rbusy_stall", stall_req, 0);
    chk("rbusy_sel", bus_sel, 0);
    chk("rbusy_wd", wb_wd, 5'd9);
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1;
    mem_op = 4'd0; mem_addr = 32'd0; mem_sdata = 32'd0;
    mem_wd = 5'd0; mem_wreg = 1'b0; mem_wdata = 32'd0;
    bus_ack = 1'b0; bus_rdata = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req", bus_req, 0);
    chk("rst_we", bus_we, 0);
    chk("rst_addr", bus_addr, 0);
    chk("rst_sel", bus_sel, 0);
    chk("rst_wdata", bus_wdata, 0);
    chk("rst_err", bus_err, 0);
    chk("rst_align", excp_align, 0);
    chk("rst_stall", stall_req, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    xact(4'd0, 32'h0,   32'h0,      32'h0,        0, 5'd5, 1'b1, 32'h1234);
    xact(4'd5, 32'h100, 32'h0,      32'hDEADBEEF, 2, 5'd3, 1'b1, 32'h0);
    xact(4'd1, 32'h103, 32'h0,      32'h000000F0, 1, 5'd7, 1'b1, 32'h0);
    xact(4'd2, 32'h103, 32'h0,      32'h000000F0, 1, 5'd7, 1'b1, 32'h0);
    xact(4'd7, 32'h102, 32'h0000ABCD, 32'h0,      1, 5'd2, 1'b1, 32'h0);
    xact(4'd5, 32'h200, 32'h0,      32'h0,        0, 5'd4, 1'b1, 32'h0);
    rst_in_busy();
    xact(4'd5, 32'h102, 32'h0,      32'h11223344, 1, 5'd6, 1'b1, 32'h0);
    xact(4'd3, 32'h102, 32'h0,      32'h1234_8765, 3, 5'd8, 1'b1, 32'h0);
    xact(4'd12, 32'h4, 32'h0,       32'h0,        0, 5'd1, 1'b1, 32'hCAFE);

    for (int i = 0; i < 300; i++) begin
      xact(4'($urandom % 16), $urandom, $urandom, $urandom,
           int'($urandom_range(0, TMO + 1)), 5'($urandom), 1'($urandom), $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
